// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter that feeds the
// first-zero detector.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_GAP
    } tx_state_t;

    localparam int FRAME_WIDTH = 8;
    localparam int GAP_CNT_W   = 4;

endpackage

// File: rtl/frame_hold_reg.sv
// One-entry holding buffer in front of the transmitter: accepts a word on
// load && ready and releases it when the frame FSM asserts take.
module frame_hold_reg
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             take,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    assign ready = !full;

    // A refill in the same edge as a take wins, so no accepted word is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (take) begin
                full <= 1'b0;
            end
            if (load && ready) begin
                full <= 1'b1;
                data <= din;
            end
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: START pulse, WIDTH data bits, GAP idle
// cycles. Define SER_MSB_FIRST_EN to send the MSB first (default LSB first).
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int   WIDTH      = FRAME_WIDTH,
    parameter int   GAP        = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             READY,
    output logic             START,
    output logic             DATAIN,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    localparam int                   CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'(GAP - 1);

`ifdef SER_MSB_FIRST_EN
    localparam int OUT_IDX = WIDTH - 1;

    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] w);
        return w << 1;
    endfunction
`else
    localparam int OUT_IDX = 0;

    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] w);
        return w >> 1;
    endfunction
`endif

    tx_state_t            state, state_n;
    logic [WIDTH-1:0]     shreg, shreg_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_n;
    logic                 launch;
    logic                 hold_full;
    logic [WIDTH-1:0]     hold_data;
    logic                 start_n, datain_n, busy_n, frame_done_n;

    frame_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (CLK),
        .rst_n (nRESET),
        .din   (DIN),
        .load  (LOAD),
        .take  (launch),
        .ready (READY),
        .full  (hold_full),
        .data  (hold_data)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        launch    = 1'b0;

        case (state)
            S_IDLE: launch = hold_full;
            S_START: begin
                state_n   = S_SHIFT;
                bit_cnt_n = '0;
            end
            S_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    if (GAP == 0) begin
                        state_n = S_IDLE;
                        launch  = hold_full;
                    end else begin
                        state_n   = S_GAP;
                        gap_cnt_n = '0;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    shreg_n   = shift_next(shreg);
                end
            end
            S_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_n = S_IDLE;
                    launch  = hold_full;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Every path back to S_START reloads the shift register in the same edge.
        if (launch) begin
            shreg_n = hold_data;
            state_n = S_START;
        end

        // Outputs are decoded from the next state and registered below.
        start_n      = (state_n == S_START);
        busy_n       = (state_n != S_IDLE);
        frame_done_n = (state_n == S_SHIFT) && (bit_cnt_n == LAST_BIT);
        datain_n     = (state_n == S_SHIFT) ? shreg_n[OUT_IDX] : IDLE_LEVEL;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            START      <= 1'b0;
            DATAIN     <= IDLE_LEVEL;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            START      <= start_n;
            DATAIN     <= datain_n;
            BUSY       <= busy_n;
            FRAME_DONE <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (GAP=2 and GAP=0) checked cycle by
// cycle against a frame-timing model; honours SER_MSB_FIRST_EN for bit order.
module tb_serial_frame_tx;

    localparam int W     = 8;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din_a, din_b;
    logic         load_a, load_b;
    logic         ready_a, start_a, datain_a, busy_a, done_a;
    logic         ready_b, start_b, datain_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(W), .GAP(GAP_A), .IDLE_LEVEL(1'b1)) u_dut_a (
        .CLK(clk), .nRESET(rst_n), .DIN(din_a), .LOAD(load_a), .READY(ready_a),
        .START(start_a), .DATAIN(datain_a), .BUSY(busy_a), .FRAME_DONE(done_a)
    );

    serial_frame_tx #(.WIDTH(W), .GAP(GAP_B), .IDLE_LEVEL(1'b1)) u_dut_b (
        .CLK(clk), .nRESET(rst_n), .DIN(din_b), .LOAD(load_b), .READY(ready_b),
        .START(start_b), .DATAIN(datain_b), .BUSY(busy_b), .FRAME_DONE(done_b)
    );

    // Reference model: each frame is described only by its START cycle.
    // A word accepted in cycle a starts at max(a+2, previous start + period).
    int           cyc;
    bit           hold_valid [2];
    logic [W-1:0] hold_word  [2];
    int           hold_since [2];
    int           last_start [2];
    logic [W-1:0] frame_word [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic logic exp_bit(input logic [W-1:0] w, input int k);
`ifdef SER_MSB_FIRST_EN
        return w[W-1-k];
`else
        return w[k];
`endif
    endfunction

    function automatic logic [W-1:0] decode(input logic [W-1:0] seq);
        logic [W-1:0] w;
        for (int k = 0; k < W; k++) begin
`ifdef SER_MSB_FIRST_EN
            w[W-1-k] = seq[k];
`else
            w[k] = seq[k];
`endif
        end
        return w;
    endfunction

    // Serial position of the first 0; an all-ones frame reports the last position.
    function automatic int first_zero(input logic [W-1:0] seq);
        for (int k = 0; k < W; k++) begin
            if (!seq[k]) return k;
        end
        return W - 1;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            hold_valid[i] = 1'b0;
            hold_word[i]  = '0;
            hold_since[i] = 0;
            last_start[i] = -1000;
            frame_word[i] = '0;
        end
    endtask

    // Expected {READY, START, DATAIN, BUSY, FRAME_DONE} for the current cycle.
    task automatic model_out(input int i, output logic [4:0] e);
        int since;
        int k;
        if (hold_valid[i] && cyc >= hold_since[i] + 1 &&
            cyc >= last_start[i] + W + 1 + gap_of(i)) begin
            last_start[i] = cyc;
            frame_word[i] = hold_word[i];
            hold_valid[i] = 1'b0;
        end
        since = cyc - last_start[i];
        k     = since - 1;
        e[4]  = !hold_valid[i];
        e[3]  = (since == 0);
        e[2]  = (k >= 0 && k < W) ? exp_bit(frame_word[i], k) : 1'b1;
        e[1]  = (since <= W + gap_of(i));
        e[0]  = (k == W - 1);
    endtask

    // One cycle: sample both DUTs at the falling edge, then drive new inputs.
    task automatic advance(input logic la, input logic [W-1:0] da,
                           input logic lb, input logic [W-1:0] db,
                           output logic [4:0] ga, output logic [4:0] ea,
                           output logic [4:0] gb, output logic [4:0] eb);
        @(negedge clk);
        model_out(0, ea);
        model_out(1, eb);
        ga = {ready_a, start_a, datain_a, busy_a, done_a};
        gb = {ready_b, start_b, datain_b, busy_b, done_b};
        load_a = la; din_a = da;
        load_b = lb; din_b = db;
        if (la && ea[4]) begin
            hold_valid[0] = 1'b1; hold_word[0] = da; hold_since[0] = cyc + 1;
        end
        if (lb && eb[4]) begin
            hold_valid[1] = 1'b1; hold_word[1] = db; hold_since[1] = cyc + 1;
        end
        cyc++;
    endtask

    task automatic test_reset();
        logic [4:0] ga, ea, gb, eb;
        rst_n = 1'b0; load_a = 1'b0; load_b = 1'b0; din_a = '0; din_b = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({ready_a, start_a, datain_a, busy_a, done_a} !== 5'b10100) begin
            bad++;
            $display("FAIL reset_idle_a got=%b exp=10100",
                     {ready_a, start_a, datain_a, busy_a, done_a});
        end
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 7; c++) begin
            advance(c == 0, 8'hC3, c == 0, 8'h3C, ga, ea, gb, eb);
            total++;
            if (ga !== ea) begin bad++; $display("FAIL reset_pre_a c=%0d got=%b exp=%b", c, ga, ea); end
            total++;
            if (gb !== eb) begin bad++; $display("FAIL reset_pre_b c=%0d got=%b exp=%b", c, gb, eb); end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ready_a, start_a, datain_a, busy_a, done_a} !== 5'b10100) begin
            bad++;
            $display("FAIL reset_mid_a got=%b exp=10100",
                     {ready_a, start_a, datain_a, busy_a, done_a});
        end
        total++;
        if ({ready_b, start_b, datain_b, busy_b, done_b} !== 5'b10100) begin
            bad++;
            $display("FAIL reset_mid_b got=%b exp=10100",
                     {ready_b, start_b, datain_b, busy_b, done_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_frame(input logic [W-1:0] word, input int exp_q);
        logic [4:0]   ga, ea, gb, eb;
        logic [W-1:0] seq = '0;
        logic [W-1:0] exp_seq;
        int           n = -1;
        int           done_k = -1;
        for (int k = 0; k < W; k++) exp_seq[k] = exp_bit(word, k);
        for (int c = 0; c < 16; c++) begin
            advance(c == 0, word, 1'b0, '0, ga, ea, gb, eb);
            total++;
            if (ga !== ea) begin bad++; $display("FAIL frame_%h_a c=%0d got=%b exp=%b", word, c, ga, ea); end
            total++;
            if (gb !== eb) begin bad++; $display("FAIL frame_%h_b c=%0d got=%b exp=%b", word, c, gb, eb); end
            if (ga[3]) begin
                n = 0;
            end else if (n >= 0 && n < W) begin
                seq[n] = ga[2];
                if (ga[0]) done_k = n;
                n++;
            end
        end
        total++;
        if (n != W) begin bad++; $display("FAIL frame_%h_bits got=%0d exp=%0d", word, n, W); end
        total++;
        if (done_k != W - 1) begin bad++; $display("FAIL frame_%h_done got=%0d exp=%0d", word, done_k, W - 1); end
        total++;
        if (seq !== exp_seq) begin bad++; $display("FAIL frame_%h_serial got=%b exp=%b", word, seq, exp_seq); end
        total++;
        if (first_zero(seq) != exp_q) begin
            bad++; $display("FAIL frame_%h_q got=%0d exp=%0d", word, first_zero(seq), exp_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ga, ea, gb, eb;
        int         starts[$];
        logic       lb;
        logic [W-1:0] db;
        int         sent = 0;
        for (int c = 0; c < 24; c++) begin
            lb = (sent < 2);
            db = (sent == 0) ? 8'h01 : 8'h80;
            advance(1'b0, '0, lb, db, ga, ea, gb, eb);
            if (lb && eb[4]) sent++;
            total++;
            if (gb !== eb) begin bad++; $display("FAIL b2b_b c=%0d got=%b exp=%b", c, gb, eb); end
            total++;
            if (ga !== ea) begin bad++; $display("FAIL b2b_a c=%0d got=%b exp=%b", c, ga, ea); end
            if (c == 1) begin
                total++;
                if (gb[4] !== 1'b0) begin bad++; $display("FAIL b2b_ready_low got=%b exp=0", gb[4]); end
            end
            if (gb[3]) starts.push_back(c);
        end
        total++;
        if (starts.size() != 2) begin
            bad++; $display("FAIL b2b_starts got=%0d exp=2", starts.size());
        end else begin
            total++;
            if (starts[1] - starts[0] != W + 1) begin
                bad++; $display("FAIL b2b_period got=%0d exp=%0d", starts[1] - starts[0], W + 1);
            end
        end
    endtask

    task automatic test_load_held();
        logic [4:0]   ga, ea, gb, eb;
        logic [W-1:0] words[3];
        logic [W-1:0] got[$];
        logic [W-1:0] seq = '0;
        logic [W-1:0] r;
        int           idx = 0;
        int           n = -1;
        r = W'($urandom);
        for (int i = 0; i < 3; i++) words[i] = r + W'(i * 85);
        for (int c = 0; c < 45; c++) begin
            advance(idx < 3, (idx < 3) ? words[idx] : '0, 1'b0, '0, ga, ea, gb, eb);
            if (idx < 3 && ea[4]) idx++;
            total++;
            if (ga !== ea) begin bad++; $display("FAIL held_a c=%0d got=%b exp=%b", c, ga, ea); end
            if (ga[3]) begin
                n = 0;
            end else if (n >= 0 && n < W) begin
                seq[n] = ga[2];
                n++;
                if (n == W) got.push_back(decode(seq));
            end
        end
        total++;
        if (got.size() != 3) begin
            bad++; $display("FAIL held_count got=%0d exp=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[i] !== words[i]) begin
                    bad++; $display("FAIL held_word%0d got=%h exp=%h", i, got[i], words[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] ga, ea, gb, eb;
        for (int c = 0; c < 300; c++) begin
            advance($urandom_range(0, 3) == 0, W'($urandom),
                    $urandom_range(0, 2) == 0, W'($urandom), ga, ea, gb, eb);
            total++;
            if (ga !== ea) begin bad++; $display("FAIL random_a c=%0d got=%b exp=%b", c, ga, ea); end
            total++;
            if (gb !== eb) begin bad++; $display("FAIL random_b c=%0d got=%b exp=%b", c, gb, eb); end
        end
    endtask

    initial begin
        test_reset();
`ifdef SER_MSB_FIRST_EN
        test_single_frame(8'hF7, 4);
        test_single_frame(8'hFF, 7);
        test_single_frame(8'h01, 0);
`else
        test_single_frame(8'hF7, 3);
        test_single_frame(8'hFF, 7);
        test_single_frame(8'h01, 1);
`endif
        test_back_to_back();
        test_load_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
